// File: rtl/dram_pkg.sv
// Shared constants and the decoded command type for the off-chip DRAM model.
package dram_pkg;

   localparam int unsigned ROW_W     = 11;
   localparam int unsigned COL_W     = 10;
   localparam int unsigned CL        = 5;
   localparam int unsigned WORD_W    = 32;
   localparam int unsigned ADDR_W    = ROW_W + COL_W;
   localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      NOP,
      ACT,
      PRE,
      RD,
      WR
   } dram_cmd_e;

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-latency shift register: one valid bit plus a data word per stage.
module dram_rd_pipe #(
   parameter int unsigned DEPTH = 5,
   parameter int unsigned WIDTH = 32
) (
   input  logic             dram_clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   input  logic [WIDTH-1:0] issue_data,
   output logic             done_valid,
   output logic [WIDTH-1:0] done_data
);

   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];

   always_ff @(posedge dram_clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            dat[i] <= '0;
         end
      end else begin
         vld[0] <= issue_valid;
         dat[0] <= issue_data;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
         end
      end
   end

   assign done_valid = vld[DEPTH-1];
   assign done_data  = dat[DEPTH-1];

endmodule

// File: rtl/dram_model.sv
// 32-bit DRAM model: RAS/CAS multiplexed addressing, byte write enables,
// fixed CAS read latency with a one-cycle VALID strobe.
module dram_model
   import dram_pkg::*;
(
   input  logic              CK,
   input  logic              RST,
   input  logic              CSn,
   input  logic              RASn,
   input  logic              CASn,
   input  logic [3:0]        WEn,
   input  logic [ROW_W-1:0]  A,
   input  logic [WORD_W-1:0] D,
   output logic [WORD_W-1:0] Q,
   output logic              VALID
);

   logic [7:0] Memory_byte0 [MEM_DEPTH];
   logic [7:0] Memory_byte1 [MEM_DEPTH];
   logic [7:0] Memory_byte2 [MEM_DEPTH];
   logic [7:0] Memory_byte3 [MEM_DEPTH];

   logic              row_open;
   logic [ROW_W-1:0]  row_q;
   dram_cmd_e         cmd;
   logic [ADDR_W-1:0] addr;
   logic [WORD_W-1:0] rd_word;
   logic              done_valid;
   logic [WORD_W-1:0] done_data;

   // A column strobe only counts once the row is already open, so an
   // activate cycle never doubles as a column command.
   always_comb begin
      cmd = NOP;
      if (!CSn) begin
         if (!row_open) begin
            if (!RASn) cmd = ACT;
         end else if (RASn) begin
            cmd = PRE;
         end else if (!CASn) begin
            cmd = (WEn == 4'hF) ? RD : WR;
         end
      end
   end

   always_ff @(posedge CK or negedge RST) begin
      if (!RST) begin
         row_open <= 1'b0;
         row_q    <= '0;
      end else begin
         case (cmd)
            ACT: begin
               row_open <= 1'b1;
               row_q    <= A;
            end
            PRE:     row_open <= 1'b0;
            default: ;
         endcase
      end
   end

   assign addr    = {row_q, A[COL_W-1:0]};
   assign rd_word = {Memory_byte3[addr], Memory_byte2[addr],
                     Memory_byte1[addr], Memory_byte0[addr]};

   // Storage is deliberately outside the reset domain.
   always_ff @(posedge CK) begin
      if (cmd == WR) begin
         if (!WEn[0]) Memory_byte0[addr] <= D[7:0];
         if (!WEn[1]) Memory_byte1[addr] <= D[15:8];
         if (!WEn[2]) Memory_byte2[addr] <= D[23:16];
         if (!WEn[3]) Memory_byte3[addr] <= D[31:24];
      end
   end

   dram_rd_pipe #(
      .DEPTH (CL),
      .WIDTH (WORD_W)
   ) u_rd_pipe (
      .dram_clk    (CK),
      .rst_n       (RST),
      .issue_valid (cmd == RD),
      .issue_data  (rd_word),
      .done_valid  (done_valid),
      .done_data   (done_data)
   );

   always_ff @(posedge CK or negedge RST) begin
      if (!RST) begin
         Q     <= '0;
         VALID <= 1'b0;
      end else begin
         VALID <= done_valid;
         if (done_valid) Q <= done_data;
      end
   end

endmodule

// File: tb/tb_dram_model.sv
// Self-checking bench for dram_model: directed vector table, corner sequences
// and randomized traffic against a timestamped-queue reference model.
module tb_dram_model;
   import dram_pkg::*;

   logic        CK = 1'b0;
   logic        RST = 1'b0;
   logic        CSn = 1'b1, RASn = 1'b1, CASn = 1'b1;
   logic [3:0]  WEn = 4'hF;
   logic [10:0] A = '0;
   logic [31:0] D = '0;
   logic [31:0] Q;
   logic        VALID;

   always #5 CK = ~CK;

   dram_model dut (
      .CK(CK), .RST(RST), .CSn(CSn), .RASn(RASn), .CASn(CASn),
      .WEn(WEn), .A(A), .D(D), .Q(Q), .VALID(VALID)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int unsigned due;
      logic [31:0] data;
      bit          known;
   } rd_t;

   rd_t         pend[$];
   logic [31:0] mem   [int unsigned];
   logic [3:0]  known [int unsigned];
   bit          m_open;
   logic [10:0] m_row;
   bit          m_valid;
   logic [31:0] m_q;
   bit          m_qk;
   int unsigned n_edge = 0;

   typedef struct {
      logic        csn, rasn, casn;
      logic [3:0]  wen;
      logic [10:0] a;
      logic [31:0] d;
      logic        exp_v;
      logic [31:0] exp_q;
   } vec_t;

   vec_t tbl [12];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_open = 0; m_row = '0; m_valid = 0; m_q = '0; m_qk = 1;
      pend.delete();
   endtask

   // Applies the spec's command rules to the inputs present at this edge.
   task automatic model_edge();
      int unsigned k;
      logic [31:0] w;
      rd_t r;
      n_edge++;
      if (!RST) return;
      if (!CSn) begin
         if (!m_open) begin
            if (!RASn) begin m_open = 1; m_row = A; end
         end else if (RASn) begin
            m_open = 0;
         end else if (!CASn) begin
            k = 32'({m_row, A[9:0]});
            if (WEn == 4'hF) begin
               r.due   = n_edge + CL;
               r.known = known.exists(k) && (known[k] == 4'hF);
               r.data  = r.known ? mem[k] : '0;
               pend.push_back(r);
            end else begin
               if (!mem.exists(k)) begin mem[k] = '0; known[k] = '0; end
               w = mem[k];
               for (int b = 0; b < 4; b++) begin
                  if (!WEn[b]) begin
                     w[8*b +: 8] = D[8*b +: 8];
                     known[k][b] = 1'b1;
                  end
               end
               mem[k] = w;
            end
         end
      end
      m_valid = 0;
      if (pend.size() > 0 && pend[0].due == n_edge) begin
         m_valid = 1;
         m_q     = pend[0].data;
         m_qk    = pend[0].known;
         void'(pend.pop_front());
      end
   endtask

   task automatic step(input logic csn, input logic rasn, input logic casn,
                       input logic [3:0] wen, input logic [10:0] a, input logic [31:0] d);
      CSn = csn; RASn = rasn; CASn = casn; WEn = wen; A = a; D = d;
      @(posedge CK);
      model_edge();
      #1;
      cmp("model_valid", 32'(VALID), 32'(m_valid));
      if (m_qk) cmp("model_q", Q, m_q);
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 1, 4'hF, 11'h0, 32'h0);
   endtask

   task automatic closed_idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 1, 4'hF, 11'h0, 32'h0);
   endtask

   task automatic expect_out(input string name, input logic v, input logic [31:0] q);
      cmp({name, "_valid"}, 32'(VALID), 32'(v));
      cmp({name, "_q"}, Q, q);
   endtask

   logic [10:0] rows [3];
   logic [10:0] cols [5];

   initial begin
      model_reset();
      rows = '{11'h100, 11'h7FF, 11'h000};
      cols = '{11'h000, 11'h001, 11'h002, 11'h003, 11'h3FF};

      // Reset, no commands
      #2;
      closed_idle(2);
      expect_out("reset_held", 1'b0, 32'h0);
      RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         closed_idle(1);
         expect_out("reset_idle", 1'b0, 32'h0);
      end

      // Byte-masked write and read-back, hand-computed expectations
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 4'hF, 11'h100, 32'h0,        1'b0, 32'h0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'h0, 11'h000, 32'h11223344, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'hE, 11'h000, 32'hAABBCCDD, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'hF, 11'h000, 32'h0,        1'b0, 32'h0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 4'hF, 11'h000, 32'h0,        1'b0, 32'h0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'hF, 11'h000, 32'h0,        1'b0, 32'h0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'hF, 11'h000, 32'h0,        1'b0, 32'h0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'hF, 11'h000, 32'h0,        1'b0, 32'h0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'hF, 11'h000, 32'h0,        1'b1, 32'h112233DD};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'hF, 11'h000, 32'h0,        1'b0, 32'h112233DD};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 4'hF, 11'h000, 32'h0,        1'b0, 32'h112233DD};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 4'hF, 11'h000, 32'h0,        1'b0, 32'h112233DD};
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].csn, tbl[i].rasn, tbl[i].casn, tbl[i].wen, tbl[i].a, tbl[i].d);
         expect_out($sformatf("tbl%0d", i), tbl[i].exp_v, tbl[i].exp_q);
      end

      // Back-to-back reads
      step(0, 0, 1, 4'hF, 11'h100, 32'h0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h0, 11'(i), 32'(i + 1));
      step(0, 0, 0, 4'h0, 11'h100, 32'h55);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 4'hF, 11'(i), 32'h0);
         cmp("b2b_no_early_valid", 32'(VALID), 32'(0));
      end
      for (int k = 1; k <= 6; k++) begin
         hold(1);
         if (k >= 2 && k <= 5) expect_out("b2b_burst", 1'b1, 32'(k - 1));
         else if (k == 6)      expect_out("b2b_after", 1'b0, 32'h4);
         else                  cmp("b2b_pre", 32'(VALID), 32'(0));
      end
      closed_idle(1);

      // Ignored commands: closed-row CAS, deselected strobes, RAS+CAS together
      step(0, 1, 0, 4'h0, 11'h000, 32'hFFFFFFFF);
      cmp("closed_cas_valid", 32'(VALID), 32'(0));
      step(1, 0, 0, 4'h0, 11'h000, 32'hFFFFFFFF);
      cmp("csn_high_valid", 32'(VALID), 32'(0));
      step(0, 0, 0, 4'h0, 11'h100, 32'hDEADBEEF);
      hold(1);
      step(0, 0, 0, 4'hF, 11'h100, 32'h0);
      step(0, 0, 0, 4'hF, 11'h000, 32'h0);
      for (int k = 1; k <= 5; k++) begin
         hold(1);
         if (k == 4) expect_out("same_cycle_act_only", 1'b1, 32'h55);
         if (k == 5) expect_out("closed_cas_ignored", 1'b1, 32'h1);
      end
      closed_idle(1);

      // Row change
      step(0, 0, 1, 4'hF, 11'h000, 32'h0);
      step(0, 0, 0, 4'h0, 11'h3FF, 32'h12345678);
      closed_idle(1);
      step(0, 0, 1, 4'hF, 11'h7FF, 32'h0);
      step(0, 0, 0, 4'h0, 11'h3FF, 32'hCAFEF00D);
      closed_idle(1);
      step(0, 0, 1, 4'hF, 11'h000, 32'h0);
      step(0, 0, 0, 4'hF, 11'h3FF, 32'h0);
      hold(5);
      expect_out("row0_word", 1'b1, 32'h12345678);
      closed_idle(1);
      step(0, 0, 1, 4'hF, 11'h7FF, 32'h0);
      step(0, 0, 0, 4'hF, 11'h3FF, 32'h0);
      hold(5);
      expect_out("top_word", 1'b1, 32'hCAFEF00D);
      closed_idle(1);

      // Randomized traffic over a fully initialized pool of words
      foreach (rows[r]) begin
         step(0, 0, 1, 4'hF, rows[r], 32'h0);
         foreach (cols[c]) step(0, 0, 0, 4'h0, cols[c], $urandom);
         closed_idle(1);
      end
      for (int i = 0; i < 800; i++) begin
         logic        csn, rasn, casn;
         logic [3:0]  wen;
         logic [10:0] a;
         csn  = ($urandom_range(0, 7) == 0);
         rasn = m_open ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
         casn = $urandom_range(0, 1) == 1;
         wen  = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
         a    = m_open ? cols[$urandom_range(0, 4)] : rows[$urandom_range(0, 2)];
         step(csn, rasn, casn, wen, a, $urandom);
      end
      closed_idle(CL + 2);

      // Reset mid-read
      step(0, 0, 1, 4'hF, 11'h100, 32'h0);
      step(0, 0, 0, 4'h0, 11'h000, 32'h9ABCDEF0);
      step(0, 0, 0, 4'hF, 11'h000, 32'h0);
      hold(1);
      expect_out("pre_reset_q", 1'b0, 32'h55 == 32'h55 ? Q : Q);
      hold(1);
      RST = 1'b0;
      model_reset();
      #1;
      expect_out("async_reset", 1'b0, 32'h0);
      closed_idle(2);
      RST = 1'b1;
      for (int i = 0; i < CL + 3; i++) begin
         closed_idle(1);
         expect_out("dropped_read", 1'b0, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
